// File: rtl/plru_state_tracker_pkg.sv
// Shared L1 cache types: 3-bit PLRU tree, way number and per-set valid mask.
package lc3b_types;

    typedef logic [2:0] lc3b_plru_state;
    typedef logic [1:0] lc3b_way;
    typedef logic [3:0] lc3b_way_valid;

    localparam lc3b_plru_state PLRU_RESET_STATE = 3'b000;

endpackage

// File: rtl/plru_state_tracker_victim_select.sv
// Victim choice for one set: the lowest invalid way if any, else the PLRU tree decode.
module plru_victim_select
    import lc3b_types::*;
(
    input  logic [2:0] tree,
    input  logic [3:0] valid,
    output logic [1:0] victim_way,
    output logic       victim_invalid
);

    lc3b_way tree_way;

    // The root bit points at the half to evict from; the node bit picks the colder way in that half.
    always_comb begin
        tree_way = 2'd0;
        if (tree[0]) begin
            tree_way = tree[1] ? 2'd0 : 2'd1;
        end else begin
            tree_way = tree[2] ? 2'd2 : 2'd3;
        end
    end

    always_comb begin
        victim_way     = tree_way;
        victim_invalid = 1'b1;
        if (!valid[0]) begin
            victim_way = 2'd0;
        end else if (!valid[1]) begin
            victim_way = 2'd1;
        end else if (!valid[2]) begin
            victim_way = 2'd2;
        end else if (!valid[3]) begin
            victim_way = 2'd3;
        end else begin
            victim_invalid = 1'b0;
        end
    end

endmodule

// File: rtl/plru_state_tracker.sv
// Per-set 4-way tree-PLRU and valid tracking with victim selection and a set-by-set flush sweep.
module plru_state_tracker
    import lc3b_types::*;
#(
    parameter  int NUM_SETS = 8,
    localparam int INDEX_W  = $clog2(NUM_SETS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               access_valid,
    input  logic [INDEX_W-1:0] access_index,
    input  logic [1:0]         access_way,
    input  logic               access_fill,
    input  logic [INDEX_W-1:0] query_index,
    output logic [1:0]         victim_way,
    output logic               victim_invalid,
    input  logic               flush_req,
    output logic               flush_busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;
    localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

    lc3b_plru_state tree_q  [NUM_SETS];
    lc3b_plru_state tree_d  [NUM_SETS];
    lc3b_way_valid  valid_q [NUM_SETS];
    lc3b_way_valid  valid_d [NUM_SETS];
    logic [0:0]         state_q, state_d;
    logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;

    // Make the tree point away from the way just used; untouched node keeps its history.
    function automatic lc3b_plru_state plru_update(input lc3b_plru_state cur, input lc3b_way way);
        lc3b_plru_state nxt;
        nxt = cur;
        case (way)
            2'd0: begin nxt[0] = 1'b0; nxt[1] = 1'b0; end
            2'd1: begin nxt[0] = 1'b0; nxt[1] = 1'b1; end
            2'd2: begin nxt[0] = 1'b1; nxt[2] = 1'b0; end
            default: begin nxt[0] = 1'b1; nxt[2] = 1'b1; end
        endcase
        return nxt;
    endfunction

    always_comb begin
        tree_d      = tree_q;
        valid_d     = valid_q;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // An access coinciding with flush_req still lands; the sweep then clears it.
                if (access_valid) begin
                    tree_d[access_index] = plru_update(tree_q[access_index], access_way);
                    if (access_fill) begin
                        valid_d[access_index][access_way] = 1'b1;
                    end
                end
                if (flush_req) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                tree_d[flush_cnt_q]  = PLRU_RESET_STATE;
                valid_d[flush_cnt_q] = '0;
                flush_cnt_d          = flush_cnt_q + 1'b1;
                if (flush_cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                tree_q[i]  <= PLRU_RESET_STATE;
                valid_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < NUM_SETS; i++) begin
                tree_q[i]  <= tree_d[i];
                valid_q[i] <= valid_d[i];
            end
        end
    end

    assign flush_busy = (state_q == ST_FLUSH);

    // Reads registered state only, so a same-cycle access to the queried set is not bypassed.
    plru_victim_select u_victim_select (
        .tree           (tree_q[query_index]),
        .valid          (valid_q[query_index]),
        .victim_way     (victim_way),
        .victim_invalid (victim_invalid)
    );

endmodule
